// File: rtl/fft_sched_pkg.sv
// Shared encodings and helpers for the FFT frame scheduler: bank and feed state
// enums, bit reversal of SDF output order, and an elaboration-time log2.
package fft_sched_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        STREAMING
    } bank_state_e;

    typedef enum logic {
        IDLE,
        STREAM
    } feed_state_e;

    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Reverses the low `width` bits of value; upper result bits are zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
        logic [31:0] src;
        logic [31:0] result;
        src    = value;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                result = {result[30:0], src[0]};
                src    = src >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame buffer: simple dual-port RAM, one write port and one registered
// read port; the read register outputs zero on cycles with no read.
module frame_bank_ram #(
    parameter int ADDR_W = 7,
    parameter int WIDTH  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_W) - 1];

    // NOTE: the storage array has no reset; resetting a memory forces it into
    // flops. Only the read register, which is a block output, is reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_en ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/fft_frame_sched.sv
// Ping-pong frame scheduler feeding an SDF FFT with unbroken N-cycle bursts and
// tracking the bit-reversed FFT output stream back to natural bin order.
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int  N     = 64,
    parameter int  WIDTH = 16,
    localparam int LOG_N = log2_ceil(N)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             fft_di_en,
    output logic [WIDTH-1:0] fft_di_re,
    output logic [WIDTH-1:0] fft_di_im,
    input  logic             fft_do_en,
    input  logic [WIDTH-1:0] fft_do_re,
    input  logic [WIDTH-1:0] fft_do_im,
    output logic             bin_valid,
    output logic [LOG_N-1:0] bin_index,
    output logic [WIDTH-1:0] bin_re,
    output logic [WIDTH-1:0] bin_im,
    output logic             bin_last,
    output logic             frame_err,
    output logic             busy
);

    localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

    bank_state_e      bank_st   [2];
    bank_state_e      bank_st_n [2];
    feed_state_e      feed_st, feed_st_n;
    logic             wbank, wbank_n, rbank, rbank_n;
    logic [LOG_N-1:0] wptr, wptr_n, raddr, raddr_n;
    logic             in_ready_n;
    logic             wr_en, rd_en;
    logic [LOG_N-1:0] ocnt;

    assign wr_en     = in_valid & in_ready;
    assign fft_di_im = '0;

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        bank_st_n = bank_st;
        wbank_n   = wbank;
        wptr_n    = wptr;
        rbank_n   = rbank;
        raddr_n   = raddr;
        feed_st_n = feed_st;
        rd_en     = 1'b0;

        // The writer only touches EMPTY/FILLING banks and the reader only
        // FULL/STREAMING ones, so the two never update the same entry.
        if (wr_en) begin
            wptr_n = wptr + 1'b1;
            if (wptr == LAST) begin
                bank_st_n[wbank] = FULL;
                wbank_n          = ~wbank;
            end else begin
                bank_st_n[wbank] = FILLING;
            end
        end

        case (feed_st)
            IDLE: begin
                if (bank_st[rbank] == FULL) begin
                    feed_st_n        = STREAM;
                    bank_st_n[rbank] = STREAMING;
                    raddr_n          = '0;
                end
            end
            STREAM: begin
                rd_en   = 1'b1;
                raddr_n = raddr + 1'b1;
                if (raddr == LAST) begin
                    bank_st_n[rbank] = EMPTY;
                    rbank_n          = ~rbank;
                    // Only a bank already FULL continues the burst; one that
                    // completes this same cycle waits for the IDLE pass.
                    if (bank_st[~rbank] == FULL) begin
                        bank_st_n[~rbank] = STREAMING;
                    end else begin
                        feed_st_n = IDLE;
                    end
                end
            end
            default: feed_st_n = IDLE;
        endcase

        in_ready_n = bank_st_n[wbank_n] inside {EMPTY, FILLING};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            feed_st    <= IDLE;
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            wptr       <= '0;
            raddr      <= '0;
            in_ready   <= 1'b0;
            fft_di_en  <= 1'b0;
        end else begin
            bank_st    <= bank_st_n;
            feed_st    <= feed_st_n;
            wbank      <= wbank_n;
            rbank      <= rbank_n;
            wptr       <= wptr_n;
            raddr      <= raddr_n;
            in_ready   <= in_ready_n;
            fft_di_en  <= rd_en;
        end
    end

    frame_bank_ram #(
        .ADDR_W (LOG_N + 1),
        .WIDTH  (WIDTH)
    ) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr ({wbank, wptr}),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr ({rbank, raddr}),
        .rd_data (fft_di_re)
    );

    // Output side: a drop of fft_do_en mid-frame resynchronises ocnt to zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ocnt      <= '0;
            bin_valid <= 1'b0;
            bin_index <= '0;
            bin_re    <= '0;
            bin_im    <= '0;
            bin_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            bin_valid <= fft_do_en;
            bin_re    <= fft_do_re;
            bin_im    <= fft_do_im;
            bin_index <= LOG_N'(bit_reverse(32'(ocnt), LOG_N));
            bin_last  <= fft_do_en && (ocnt == LAST);
            if (fft_do_en) begin
                ocnt <= ocnt + 1'b1;
            end else if (ocnt != '0) begin
                frame_err <= 1'b1;
                ocnt      <= '0;
            end
        end
    end

    assign busy = (bank_st[0] inside {FULL, STREAMING}) ||
                  (bank_st[1] inside {FULL, STREAMING}) ||
                  (feed_st != IDLE) || (ocnt != '0);

endmodule
